// File: rtl/ni_emit_arbiter_if.sv
// Bundle of the two FIFO read ports and the NI output link served by ni_emit_arbiter.
// master = arbiter side, slave = FIFOs plus downstream link.
interface ni_emit_arbiter_if #(
    parameter int unsigned DataWidth = 32
);
    logic                 PrioEmpty_i;
    logic [DataWidth-1:0] PrioData_i;
    logic                 PrioRead_o;
    logic                 RegEmpty_i;
    logic [DataWidth-1:0] RegData_i;
    logic                 RegRead_o;
    logic                 Valid_o;
    logic [DataWidth-1:0] Data_o;
    logic                 Ready_i;
    logic                 SrcPrio_o;

    modport master (
        input  PrioEmpty_i, PrioData_i, RegEmpty_i, RegData_i, Ready_i,
        output PrioRead_o, RegRead_o, Valid_o, Data_o, SrcPrio_o
    );

    modport slave (
        output PrioEmpty_i, PrioData_i, RegEmpty_i, RegData_i, Ready_i,
        input  PrioRead_o, RegRead_o, Valid_o, Data_o, SrcPrio_o
    );
endinterface

// File: rtl/ni_emit_arbiter.sv
// Drains a priority and a regular flit FIFO onto one Valid/Ready link, priority first.
// Build option: define NI_ARB_FAIRNESS_EN to cap consecutive priority grants at PrioBurst.
module ni_emit_arbiter #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned PrioBurst = 4
) (
    input  logic               clk,
    input  logic               rstn,
    ni_emit_arbiter_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    if (PrioBurst < 1) begin : gBadBurst
        $error("ni_emit_arbiter: PrioBurst must be at least 1");
    end

    state_t               stateReg;
    logic                 selPrioReg;
    logic                 validReg;
    logic [DataWidth-1:0] dataReg;
    logic                 srcPrioReg;

    logic decide;
    logic pickPrio;
    logic grantPrio;
    logic grantReg;

`ifdef NI_ARB_FAIRNESS_EN
    localparam int unsigned BurstW = $clog2(PrioBurst + 1);
    localparam logic [BurstW-1:0] BurstMax = BurstW'(PrioBurst);

    logic [BurstW-1:0] burstCntReg;
`endif

    // Decisions happen when idle, or when the held flit is being accepted this cycle.
    always_comb begin
        decide = (stateReg == IDLE) || ((stateReg == HOLD) && bus.Ready_i);
`ifdef NI_ARB_FAIRNESS_EN
        pickPrio = !bus.PrioEmpty_i && (bus.RegEmpty_i || (burstCntReg != BurstMax));
`else
        pickPrio = !bus.PrioEmpty_i;
`endif
        grantPrio = decide && pickPrio;
        grantReg  = decide && !pickPrio && !bus.RegEmpty_i;
    end

    assign bus.PrioRead_o = grantPrio && rstn;
    assign bus.RegRead_o  = grantReg && rstn;
    assign bus.Valid_o    = validReg;
    assign bus.Data_o     = dataReg;
    assign bus.SrcPrio_o  = srcPrioReg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stateReg   <= IDLE;
            selPrioReg <= 1'b0;
            validReg   <= 1'b0;
            dataReg    <= '0;
            srcPrioReg <= 1'b0;
        end else begin
            case (stateReg)
                IDLE, HOLD: begin
                    if (decide) begin
                        validReg <= 1'b0;
                        if (grantPrio || grantReg) begin
                            stateReg   <= FETCH;
                            selPrioReg <= grantPrio;
                        end else begin
                            stateReg <= IDLE;
                        end
                    end
                end
                FETCH: begin
                    // FIFO read data is valid one cycle after the strobe.
                    dataReg    <= selPrioReg ? bus.PrioData_i : bus.RegData_i;
                    srcPrioReg <= selPrioReg;
                    validReg   <= 1'b1;
                    stateReg   <= HOLD;
                end
                default: begin
                    stateReg <= IDLE;
                    validReg <= 1'b0;
                end
            endcase
        end
    end

`ifdef NI_ARB_FAIRNESS_EN
    // Counts priority wins while the regular queue waits; any decision without
    // regular work pending, or a regular win, restarts the run.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            burstCntReg <= '0;
        end else if (decide) begin
            if (bus.RegEmpty_i || grantReg) begin
                burstCntReg <= '0;
            end else if (grantPrio && (burstCntReg != BurstMax)) begin
                burstCntReg <= burstCntReg + BurstW'(1);
            end
        end
    end
`endif

endmodule
